commit_trace_sink: RTL and testbench
====================================

// Module: commit_trace_sink
// PURPOSE
//   Receiving end of the CPU commit/debug bus. Captures one record per retired instruction
//   into a FIFO and drains it to the host over a valid/ready stream.
//   Throttles the CPU through its global_en input so no record is ever lost.
//   Counts retired instructions, detects ebreak (commit_halt), and signals done once the
//   trace is fully drained. Sits between the CPU and the host/debug link.
// PARAMETERS
//   DEPTH   16   FIFO entries; power of 2, >= 4
//   AW      4    log2(DEPTH)
// PORTS
//   clk             in   1    clock
//   rst             in   1    synchronous, active-high reset
//   run_i           in   1    host request to execute
//   cpu_en_o        out  1    drives CPU global_en
//   commit_i        in   1    CPU commit valid; sticky, stays high after the first retire
//   commit_pc_i     in   32   retired PC
//   commit_instr_i  in   32   retired instruction
//   commit_halt_i   in   1    retired instruction is ebreak
//   commit_reg_we_i in   1    RF write enable;  commit_reg_wa_i 5 / commit_reg_wd_i 32
//   commit_dmem_we_i in  1    store enable;     commit_dmem_wa_i 32 / commit_dmem_wd_i 32
//   trace_valid_o   out  1    record available
//   trace_ready_i   in   1    host accepts record
//   trace_data_o    out  REC_W  packed record, FIFO head
//   instret_o       out  32   retired instruction count
//   done_o          out  1    halt seen and FIFO empty
//   ovf_o           out  1    sticky: push attempted while FIFO full
// BEHAVIOUR
//   - Reset: FIFO empty; instret_o = 0; done_o = 0; ovf_o = 0; en_q = 0; FSM = RUN; cpu_en_o = 0.
//   - New retire detection
//     - en_q = global_en registered from cpu_en_o.
//     - push = commit_i & en_q. The CPU commit regs update one cycle after an enabled cycle.
//     - A held commit_i with en_q = 0 is NOT a new record.
//   - Throttle: cpu_en_o = run_i & (state == RUN) & ~(push & commit_halt_i) & (count <= DEPTH-2).
//     - count is the registered occupancy.
//     - This leaves one slot for the in-flight retire, so a compliant host never causes overflow.
//   - FIFO
//     - Push and pop in the same cycle are both allowed.
//     - Pop happens when trace_valid_o & trace_ready_i.
//     - Full + push + pop succeeds.
//     - Full + push, no pop: record dropped, ovf_o set.
//     - trace_valid_o = ~empty. trace_data_o is stable while valid & ~ready.
//     - First-word latency: the record is visible the cycle after push.
//   - Record layout, MSB..LSB:
//     - pc[32], instr[32], halt[1], reg_we[1], reg_wa[5], reg_wd[32], dmem_we[1], dmem_wa[32], dmem_wd[32].
//     - REC_W = 199.
//   - instret_o += 1 on every push; wraps modulo 2^32; includes the halt instruction.
//   - FSM
//     - RUN   -> DRAIN on push & commit_halt_i.
//     - DRAIN -> DONE when the FIFO is empty (count == 0 and no push).
//     - DONE  holds until rst; done_o = 1 only in DONE.
//     - cpu_en_o = 0 in DRAIN and DONE. Host popping continues in DRAIN.
//   - run_i low: CPU stalls, FIFO keeps draining. The retire in flight from the last enabled cycle is still captured.
//   - Reset mid-operation discards all FIFO contents and counters the same cycle.
// CONFIGURATION
//   - COMMIT_TRACE_CYCLE_EN defined:
//     - A 32-bit free-running cycle counter (0 at reset, wraps) is appended as record LSBs.
//     - REC_W = 231. The stamp is the counter value in the push cycle.
//   - COMMIT_TRACE_CYCLE_EN undefined: no counter; REC_W = 199.
// STRUCTURE
//   - Shared package commit_trace_pkg:
//     - REC_W, field offset/width localparams, FSM state encoding (RUN/DRAIN/DONE).
//     - HALT_INSTR = 32'h0010_0073.
//   - Sub-module trace_fifo (DEPTH, WIDTH):
//     - Synchronous FIFO with wrap-around pointers and an AW+1-bit count.
//     - Outputs full, empty, count, ovf.
// TESTING
//   1. Five retires, host ready=1 -> five records in order, PCs 0,4,8,C,10; instret_o=5; ovf_o=0.
//   2. Host ready=0, run_i=1, DEPTH=16 -> cpu_en_o drops once count=15; FIFO ends at 16, never drops.
//      Releasing ready drains all 16 in order.
//   3. Retire of instr 32'h00100073 -> cpu_en_o=0 the same cycle; FSM enters DRAIN.
//      After the last pop, done_o=1 and instret_o counts the halt.
//   4. commit_i held high with run_i=0 for 10 cycles -> no pushes; instret_o unchanged.
//   5. Full FIFO, host ready=0, forced push via a bench-driven en_q -> ovf_o=1 sticky, head record unchanged.
//      Full FIFO + push + pop in the same cycle -> count stays 16, no ovf.
//   6. rst asserted with 7 queued -> next cycle trace_valid_o=0, instret_o=0, FSM=RUN.
//      With COMMIT_TRACE_CYCLE_EN: stamps of back-to-back retires differ by 1.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// Shared record layout, FSM encoding and packing helper for the commit trace sink.
// COMMIT_TRACE_CYCLE_EN appends a 32-bit cycle stamp as the record LSBs.
package commit_trace_pkg;

`ifdef COMMIT_TRACE_CYCLE_EN
  localparam int STAMP_W = 32;
`else
  localparam int STAMP_W = 0;
`endif

  // The fields fill 168 bits; the record is a fixed 199 bits (+stamp), upper bits zero.
  localparam int REC_W       = 199 + STAMP_W;
  localparam int DMEM_WD_LSB = STAMP_W;
  localparam int DMEM_WA_LSB = STAMP_W + 32;
  localparam int DMEM_WE_LSB = STAMP_W + 64;
  localparam int REG_WD_LSB  = STAMP_W + 65;
  localparam int REG_WA_LSB  = STAMP_W + 97;
  localparam int REG_WE_LSB  = STAMP_W + 102;
  localparam int HALT_LSB    = STAMP_W + 103;
  localparam int INSTR_LSB   = STAMP_W + 104;
  localparam int PC_LSB      = STAMP_W + 136;

  localparam logic [31:0] HALT_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [REC_W-1:0] pack_fields(
    input logic [31:0] pc,
    input logic [31:0] instr,
    input logic        halt,
    input logic        reg_we,
    input logic [4:0]  reg_wa,
    input logic [31:0] reg_wd,
    input logic        dmem_we,
    input logic [31:0] dmem_wa,
    input logic [31:0] dmem_wd
  );
    logic [REC_W-1:0] r;
    r = '0;
    r[PC_LSB +: 32]      = pc;
    r[INSTR_LSB +: 32]   = instr;
    r[HALT_LSB]          = halt;
    r[REG_WE_LSB]        = reg_we;
    r[REG_WA_LSB +: 5]   = reg_wa;
    r[REG_WD_LSB +: 32]  = reg_wd;
    r[DMEM_WE_LSB]       = dmem_we;
    r[DMEM_WA_LSB +: 32] = dmem_wa;
    r[DMEM_WD_LSB +: 32] = dmem_wd;
    return r;
  endfunction

endpackage

// File: rtl/commit_trace_if.sv
// CPU commit bus plus host trace stream; master = CPU/host side, slave = trace sink.
interface commit_trace_if;
  import commit_trace_pkg::*;

  logic             commit_i;
  logic [31:0]      commit_pc_i;
  logic [31:0]      commit_instr_i;
  logic             commit_halt_i;
  logic             commit_reg_we_i;
  logic [4:0]       commit_reg_wa_i;
  logic [31:0]      commit_reg_wd_i;
  logic             commit_dmem_we_i;
  logic [31:0]      commit_dmem_wa_i;
  logic [31:0]      commit_dmem_wd_i;
  logic             trace_valid_o;
  logic             trace_ready_i;
  logic [REC_W-1:0] trace_data_o;

  modport master (
    output commit_i, commit_pc_i, commit_instr_i, commit_halt_i,
           commit_reg_we_i, commit_reg_wa_i, commit_reg_wd_i,
           commit_dmem_we_i, commit_dmem_wa_i, commit_dmem_wd_i,
           trace_ready_i,
    input  trace_valid_o, trace_data_o
  );

  modport slave (
    input  commit_i, commit_pc_i, commit_instr_i, commit_halt_i,
           commit_reg_we_i, commit_reg_wa_i, commit_reg_wd_i,
           commit_dmem_we_i, commit_dmem_wa_i, commit_dmem_wd_i,
           trace_ready_i,
    output trace_valid_o, trace_data_o
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-around pointers, registered occupancy and sticky overflow.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             ovf_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A simultaneous pop frees the head slot, so a full FIFO still accepts the push.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      if (push_i & ~do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/commit_trace_sink.sv
// Captures one record per retired instruction, throttles the CPU and drains to the host.
// COMMIT_TRACE_CYCLE_EN adds a free-running cycle stamp to each record.
module commit_trace_sink
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  output logic                 cpu_en_o,
  commit_trace_if.slave        bus,
  output logic [31:0]          instret_o,
  output logic                 done_o,
  output logic                 ovf_o
);
  state_t           state_q, state_d;
  logic             en_q;
  logic             push;
  logic [31:0]      instret_q;
  logic [AW:0]      count;
  logic             fifo_full, fifo_empty;
  logic [REC_W-1:0] rec;
  logic             unused_full;

  // Commit regs only hold a fresh retire in the cycle after an enabled cycle.
  assign push     = bus.commit_i & en_q;
  assign cpu_en_o = run_i & (state_q == ST_RUN) & ~(push & bus.commit_halt_i)
                  & (count <= (AW+1)'(DEPTH - 2));

`ifdef COMMIT_TRACE_CYCLE_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + 32'd1;
  end
`endif

  always_comb begin
    rec = pack_fields(bus.commit_pc_i, bus.commit_instr_i, bus.commit_halt_i,
                      bus.commit_reg_we_i, bus.commit_reg_wa_i, bus.commit_reg_wd_i,
                      bus.commit_dmem_we_i, bus.commit_dmem_wa_i, bus.commit_dmem_wd_i);
`ifdef COMMIT_TRACE_CYCLE_EN
    rec[STAMP_W-1:0] = cyc_q;
`endif
  end

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (bus.trace_ready_i),
    .wdata_i (rec),
    .rdata_o (bus.trace_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count),
    .ovf_o   (ovf_o)
  );

  assign unused_full       = fifo_full;
  assign bus.trace_valid_o = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      en_q      <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= cpu_en_o;
      if (push) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (push & bus.commit_halt_i) state_d = ST_DRAIN;
      ST_DRAIN: if ((count == '0) && !push)   state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  assign instret_o = instret_q;
  assign done_o    = (state_q == ST_DONE);
endmodule

// File: tb/tb_commit_trace_sink.sv
// Directed bench for commit_trace_sink with a small CPU commit model and a pop scoreboard.
module tb_commit_trace_sink;
  import commit_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int SH    = REC_W - 199;

  logic        clk, rst, run_i, cpu_en_o, done_o, ovf_o;
  logic [31:0] instret_o;
  logic [31:0] next_pc;
  logic [31:0] saved;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          loads   = 0;
  int          halt_idx = -1;
  logic [REC_W-1:0] pops [$];

  commit_trace_if bus();

  commit_trace_sink #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run_i     (run_i),
    .cpu_en_o  (cpu_en_o),
    .bus       (bus),
    .instret_o (instret_o),
    .done_o    (done_o),
    .ovf_o     (ovf_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [198:0] exp_rec(input logic [31:0] pc, input logic halt);
    logic [31:0] ins;
    ins = halt ? HALT_INSTR : 32'h0000_0013;
    return {31'd0, pc, ins, halt, 1'b1, pc[6:2], pc ^ 32'hA5A5_0000,
            pc[2], 32'h1000_0000 + pc, ~pc};
  endfunction

  function automatic logic [31:0] rec_pc(input logic [REC_W-1:0] r);
    return r[SH+136 +: 32];
  endfunction

  // One clock: sample enable/handshake before the edge, update the CPU commit regs after it.
  task automatic step();
    logic en_seen;
    #1;
    en_seen = cpu_en_o;
    if (bus.trace_valid_o && bus.trace_ready_i) pops.push_back(bus.trace_data_o);
    @(posedge clk);
    #1;
    if (en_seen) begin
      logic hl;
      hl = (loads == halt_idx);
      bus.commit_i         = 1'b1;
      bus.commit_pc_i      = next_pc;
      bus.commit_instr_i   = hl ? HALT_INSTR : 32'h0000_0013;
      bus.commit_halt_i    = hl;
      bus.commit_reg_we_i  = 1'b1;
      bus.commit_reg_wa_i  = next_pc[6:2];
      bus.commit_reg_wd_i  = next_pc ^ 32'hA5A5_0000;
      bus.commit_dmem_we_i = next_pc[2];
      bus.commit_dmem_wa_i = 32'h1000_0000 + next_pc;
      bus.commit_dmem_wd_i = ~next_pc;
      next_pc = next_pc + 32'd4;
      loads++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_i = 1'b0;
    bus.trace_ready_i = 1'b0;
    bus.commit_i = 1'b0;
    bus.commit_halt_i = 1'b0;
    next_pc = '0;
    loads = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pops.delete();
  endtask

  task automatic run_retires(input int n, input int extra);
    int start;
    start = loads;
    run_i = 1'b1;
    for (int i = 0; i < 200 && (loads - start) < n; i++) step();
    run_i = 1'b0;
    check("retire_budget", loads - start, n);
    repeat (extra) step();
  endtask

  initial begin
    rst = 1'b1;
    run_i = 1'b0;
    bus.trace_ready_i = 1'b0;
    bus.commit_i = 1'b0;
    bus.commit_pc_i = '0;
    bus.commit_instr_i = '0;
    bus.commit_halt_i = 1'b0;
    bus.commit_reg_we_i = 1'b0;
    bus.commit_reg_wa_i = '0;
    bus.commit_reg_wd_i = '0;
    bus.commit_dmem_we_i = 1'b0;
    bus.commit_dmem_wa_i = '0;
    bus.commit_dmem_wd_i = '0;
    next_pc = '0;
    repeat (2) @(posedge clk);
    do_reset();

    check("rst_valid", bus.trace_valid_o, 0);
    check("rst_instret", instret_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_cpu_en", cpu_en_o, 0);
    check("rst_state", dut.state_q, ST_RUN);

    // Five retires with an always-ready host
    bus.trace_ready_i = 1'b1;
    run_retires(5, 4);
    check("t1_pops", pops.size(), 5);
    for (int i = 0; i < 5 && i < pops.size(); i++)
      check($sformatf("t1_pc%0d", i), rec_pc(pops[i]), 32'(4 * i));
    if (pops.size() > 0) check("t1_rec0", pops[0] >> SH, exp_rec(32'h0, 1'b0));
    check("t1_instret", instret_o, 5);
    check("t1_ovf", ovf_o, 0);
`ifdef COMMIT_TRACE_CYCLE_EN
    if (pops.size() > 1) check("t1_stamp_step", pops[1][31:0] - pops[0][31:0], 1);
`endif

    // Host stalled: CPU throttled, FIFO fills to exactly DEPTH
    do_reset();
    run_i = 1'b1;
    repeat (22) step();
    check("t2_loads", loads, 16);
    check("t2_cpu_en", cpu_en_o, 0);
    check("t2_count", dut.u_fifo.count_q, 16);
    check("t2_ovf", ovf_o, 0);
    check("t2_head", bus.trace_data_o >> SH, exp_rec(32'h0, 1'b0));
    run_i = 1'b0;
    bus.trace_ready_i = 1'b1;
    repeat (20) step();
    check("t2_pops", pops.size(), 16);
    for (int i = 0; i < 16 && i < pops.size(); i++)
      check($sformatf("t2_pc%0d", i), rec_pc(pops[i]), 32'(4 * i));
    check("t2_instret", instret_o, 16);

    // Held commit_i with the CPU stopped is not a new record
    saved = instret_o;
    repeat (10) step();
    check("t4_instret", instret_o, saved);
    check("t4_valid", bus.trace_valid_o, 0);
    check("t4_loads", loads, 16);

    // ebreak retire: throttle same cycle, drain, then done
    do_reset();
    halt_idx = 2;
    bus.trace_ready_i = 1'b1;
    run_i = 1'b1;
    repeat (3) step();
    #1;
    check("t3_cpu_en_halt", cpu_en_o, 0);
    step();
    check("t3_state_drain", dut.state_q, ST_DRAIN);
    check("t3_done_early", done_o, 0);
    for (int i = 0; i < 20 && !done_o; i++) step();
    check("t3_done", done_o, 1);
    check("t3_instret", instret_o, 3);
    check("t3_pops", pops.size(), 3);
    if (pops.size() == 3) check("t3_halt_rec", pops[2] >> SH, exp_rec(32'h8, 1'b1));
    check("t3_cpu_en_done", cpu_en_o, 0);
    halt_idx = -1;
    run_i = 1'b0;

    // Full FIFO with forced pushes
    do_reset();
    run_i = 1'b1;
    repeat (20) step();
    run_i = 1'b0;
    check("t5_full", dut.u_fifo.count_q, 16);
    force dut.en_q = 1'b1;
    bus.trace_ready_i = 1'b1;
    step();
    check("t5_pp_count", dut.u_fifo.count_q, 16);
    check("t5_pp_ovf", ovf_o, 0);
    check("t5_pp_head", bus.trace_data_o >> SH, exp_rec(32'h4, 1'b0));
    bus.trace_ready_i = 1'b0;
    step();
    check("t5_ovf", ovf_o, 1);
    check("t5_head", bus.trace_data_o >> SH, exp_rec(32'h4, 1'b0));
    check("t5_count", dut.u_fifo.count_q, 16);
    release dut.en_q;
    repeat (2) step();
    check("t5_ovf_sticky", ovf_o, 1);

    // First-word latency, then reset with records queued
    do_reset();
    run_i = 1'b1;
    step();
    check("t6_pre_push_valid", bus.trace_valid_o, 0);
    step();
    check("t6_first_word", bus.trace_valid_o, 1);
    run_retires(5, 2);
    check("t6_count", dut.u_fifo.count_q, 7);
    check("t6_instret", instret_o, 7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_rst_valid", bus.trace_valid_o, 0);
    check("t6_rst_instret", instret_o, 0);
    check("t6_rst_state", dut.state_q, ST_RUN);
    check("t6_rst_ovf", ovf_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
